// File: rtl/vga_timing.sv
// 640x480@60 VGA raster generator: pixel-rate enable, hc/vc counters and
// pixel-aligned registered RGB, syncs, active flag and frame-start pulse.
module vga_timing #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hc,
    output logic [9:0] vc,
    input  logic [2:0] red_in,
    input  logic [2:0] green_in,
    input  logic [1:0] blue_in,
    output logic       pix_en,
    output logic [2:0] vga_r,
    output logic [2:0] vga_g,
    output logic [1:0] vga_b,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hc_q, hc_d, vc_q, vc_d;
    logic [2:0]       r_q, r_d, g_q, g_d;
    logic [1:0]       b_q, b_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             act_q, act_d, fs_q, fs_d;
    logic             vis;

    // With CLK_DIV=1 the divider is pinned at 0, so pix_en stays high.
    assign pix_en = (div_q == DIV_W'(CLK_DIV - 1));
    assign vis    = (hc_q < 10'(H_ACTIVE)) && (vc_q < 10'(V_ACTIVE));

    // Next-state: divider, raster counters and pin registers.
    always_comb begin
        div_d = div_q;
        hc_d  = hc_q;
        vc_d  = vc_q;
        r_d   = r_q;
        g_d   = g_q;
        b_d   = b_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        act_d = act_q;
        fs_d  = 1'b0;

        div_d = pix_en ? '0 : div_q + DIV_W'(1);

        if (pix_en) begin
            if (hc_q == 10'(H_TOTAL - 1)) begin
                hc_d = '0;
                vc_d = (vc_q == 10'(V_TOTAL - 1)) ? '0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end

            // Pins sample the pre-edge position: one pixel of latency for all.
            r_d   = vis ? red_in   : 3'd0;
            g_d   = vis ? green_in : 3'd0;
            b_d   = vis ? blue_in  : 2'd0;
            act_d = vis;
            hs_d  = !((hc_q >= 10'(HS_START)) && (hc_q < 10'(HS_END)));
            vs_d  = !((vc_q >= 10'(VS_START)) && (vc_q < 10'(VS_END)));
            fs_d  = (hc_q == 10'd0) && (vc_q == 10'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            hc_q  <= '0;
            vc_q  <= '0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            act_q <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            act_q <= act_d;
            fs_q  <= fs_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign active      = act_q;
    assign frame_start = fs_q;

endmodule
